// File: rtl/pipelined_datapath.sv
// Three-stage CR16 datapath: S0 operand select with full forwarding, S1 operand latch + ALU,
// S2 result latch feeding register-file writeback.
module pipelined_datapath #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_COUNT      = 16,
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET,
  input  logic                      I_ENABLE,
  input  logic                      I_VALID,
  input  logic [3:0]                I_OPCODE,
  input  logic [REG_ADDR_WIDTH-1:0] I_REG_A_SELECT,
  input  logic [REG_ADDR_WIDTH-1:0] I_REG_B_SELECT,
  input  logic [REG_ADDR_WIDTH-1:0] I_REG_DEST_SELECT,
  input  logic                      I_WRITE,
  input  logic                      I_IMMEDIATE_SELECT,
  input  logic [DATA_WIDTH-1:0]     I_IMMEDIATE,
  input  logic                      I_REG_DATA_SELECT,
  input  logic [DATA_WIDTH-1:0]     I_REG_DATA,
  output logic [DATA_WIDTH-1:0]     O_A,
  output logic [DATA_WIDTH-1:0]     O_B,
  output logic [DATA_WIDTH-1:0]     O_RESULT_BUS,
  output logic                      O_RESULT_VALID,
  output logic [REG_ADDR_WIDTH-1:0] O_RESULT_DEST,
  output logic [4:0]                O_STATUS_FLAGS
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = REG_ADDR_WIDTH;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_MOV = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1100;

  logic [W-1:0]  rf_q [REG_COUNT];

  logic          s1_valid_q;
  logic [3:0]    s1_opcode_q;
  logic [AW-1:0] s1_dest_q;
  logic          s1_write_q;
  logic [W-1:0]  s1_a_q, s1_b_q;
  logic          s1_load_q;
  logic [W-1:0]  s1_load_data_q;

  logic          s2_valid_q;
  logic [AW-1:0] s2_dest_q;
  logic          s2_write_q;
  logic [W-1:0]  s2_result_q;

  logic [4:0]    flags_q;

  logic [W-1:0]  op_a_d, op_b_d;
  logic          write_d;
  logic [W-1:0]  s1_result;
  logic [W-1:0]  alu_res;
  logic          flags_upd;
  logic [4:0]    flags_d;
  logic [W:0]    sum_ext, diff_ext;
  logic          s1_fwd, s2_fwd;

  // CMP through the ALU never commits; folding that in here keeps forwarding honest.
  assign write_d = I_WRITE & ~((I_OPCODE == OP_CMP) & ~I_REG_DATA_SELECT);

  assign s1_fwd = s1_valid_q & s1_write_q;
  assign s2_fwd = s2_valid_q & s2_write_q;

  always_comb begin
    op_a_d = rf_q[I_REG_A_SELECT];
    if (s2_fwd && (s2_dest_q == I_REG_A_SELECT)) op_a_d = s2_result_q;
    if (s1_fwd && (s1_dest_q == I_REG_A_SELECT)) op_a_d = s1_result;

    op_b_d = rf_q[I_REG_B_SELECT];
    if (s2_fwd && (s2_dest_q == I_REG_B_SELECT)) op_b_d = s2_result_q;
    if (s1_fwd && (s1_dest_q == I_REG_B_SELECT)) op_b_d = s1_result;
    if (I_IMMEDIATE_SELECT) op_b_d = I_IMMEDIATE;
  end

  assign sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};

  // Flags are packed {C, L, F, Z, N}.
  always_comb begin
    alu_res   = '0;
    flags_upd = 1'b0;
    flags_d   = flags_q;
    case (s1_opcode_q)
      OP_ADD: begin
        alu_res   = sum_ext[W-1:0];
        flags_upd = 1'b1;
        flags_d   = {sum_ext[W], 1'b0,
                     (s1_a_q[W-1] == s1_b_q[W-1]) && (sum_ext[W-1] != s1_a_q[W-1]),
                     (sum_ext[W-1:0] == '0), sum_ext[W-1]};
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff_ext[W-1:0];
        flags_upd = 1'b1;
        flags_d   = {diff_ext[W], diff_ext[W],
                     (s1_a_q[W-1] != s1_b_q[W-1]) && (diff_ext[W-1] != s1_a_q[W-1]),
                     (s1_a_q == s1_b_q), ($signed(s1_a_q) < $signed(s1_b_q))};
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
      OP_NOT: alu_res = ~s1_a_q;
      OP_MOV: alu_res = s1_b_q;
      default: alu_res = '0;
    endcase
  end

  assign s1_result = s1_load_q ? s1_load_data_q : alu_res;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s1_valid_q     <= 1'b0;
      s1_opcode_q    <= '0;
      s1_dest_q      <= '0;
      s1_write_q     <= 1'b0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_load_q      <= 1'b0;
      s1_load_data_q <= '0;
      s2_valid_q     <= 1'b0;
      s2_dest_q      <= '0;
      s2_write_q     <= 1'b0;
      s2_result_q    <= '0;
      flags_q        <= '0;
    end else if (I_ENABLE) begin
      s1_valid_q     <= I_VALID;
      s1_opcode_q    <= I_OPCODE;
      s1_dest_q      <= I_REG_DEST_SELECT;
      s1_write_q     <= write_d;
      s1_a_q         <= op_a_d;
      s1_b_q         <= op_b_d;
      s1_load_q      <= I_REG_DATA_SELECT;
      s1_load_data_q <= I_REG_DATA;
      s2_valid_q     <= s1_valid_q;
      s2_dest_q      <= s1_dest_q;
      s2_write_q     <= s1_write_q;
      s2_result_q    <= s1_result;
      if (s1_valid_q && !s1_load_q && flags_upd) flags_q <= flags_d;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (I_ENABLE && s2_valid_q && s2_write_q) begin
      rf_q[s2_dest_q] <= s2_result_q;
    end
  end

  assign O_A            = s1_a_q;
  assign O_B            = s1_b_q;
  assign O_RESULT_BUS   = s2_result_q;
  assign O_RESULT_VALID = s2_valid_q;
  assign O_RESULT_DEST  = s2_dest_q;
  assign O_STATUS_FLAGS = flags_q;

endmodule
